// File: rtl/pipeline_stall_controller.sv
// Stall/bubble control for a 5-stage pipeline: multdiv sequencing and
// load-use interlock between the F/D and D/X registers.
module pipeline_stall_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inFD,
  input  logic [31:0] inDX,
  input  logic        multdivRdy,
  input  logic        multdivExc,
  output logic        stallPC,
  output logic        stallFD,
  output logic        stallDX,
  output logic        bubbleDX,
  output logic        bubbleXM,
  output logic        ctrlMULT,
  output logic        ctrlDIV,
  output logic        mdValid,
  output logic        mdOvf,
  output logic        mdTimeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [5:0] TMO_LIMIT = 6'd40;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] cnt_inc;
  logic       div_q, div_d;
  logic       ovf_q, ovf_d;
  logic       tmo_q, tmo_d;

  logic [4:0] op_dx, alu_dx, rd_dx;
  logic [4:0] op_fd, rs_fd, rt_fd, rd_fd;
  logic       dx_mul, dx_div, dx_md, dx_lw;
  logic       fd_r, fd_br;
  logic       hazard;
  logic       md_stall, lu_stall;
  logic       unused;

  assign op_dx  = inDX[31:27];
  assign rd_dx  = inDX[26:22];
  assign alu_dx = inDX[6:2];
  assign op_fd  = inFD[31:27];
  assign rd_fd  = inFD[26:22];
  assign rs_fd  = inFD[21:17];
  assign rt_fd  = inFD[16:12];
  assign unused = ^{inFD[11:0], inDX[21:7], inDX[1:0]};

  assign dx_mul = (op_dx == 5'd0) && (alu_dx == 5'd6);
  assign dx_div = (op_dx == 5'd0) && (alu_dx == 5'd7);
  assign dx_md  = dx_mul | dx_div;
  assign dx_lw  = (op_dx == 5'd8);

  // bne/jr/blt read the rd field; sw's store data is forwarded instead
  assign fd_r  = (op_fd == 5'd0);
  assign fd_br = (op_fd == 5'd2) | (op_fd == 5'd4) | (op_fd == 5'd6);

  assign hazard = dx_lw && (rd_dx != 5'd0) &&
                  ((rs_fd == rd_dx) ||
                   (fd_r && rt_fd == rd_dx) ||
                   (fd_br && rd_fd == rd_dx));

  assign cnt_inc = cnt_q + 6'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (dx_md) begin
          state_d = START;
          div_d   = dx_div;
        end
      end
      START: begin
        state_d = BUSY;
        cnt_d   = 6'd0;
      end
      BUSY: begin
        if (multdivRdy) begin
          state_d = DONE;
          ovf_d   = multdivExc;
        end else if (cnt_inc == TMO_LIMIT) begin
          state_d = DONE;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      div_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // reset gates the input-dependent IDLE outputs as well
  assign md_stall = reset &&
                    ((state_q == IDLE && dx_md) ||
                     state_q == START ||
                     state_q == BUSY);
  assign lu_stall = reset && state_q == IDLE &&
                    !dx_md && hazard;

  assign stallPC   = md_stall | lu_stall;
  assign stallFD   = md_stall | lu_stall;
  assign stallDX   = md_stall;
  assign bubbleXM  = md_stall;
  assign bubbleDX  = lu_stall;
  assign ctrlMULT  = reset && state_q == START && !div_q;
  assign ctrlDIV   = reset && state_q == START && div_q;
  assign mdValid   = reset && state_q == DONE;
  assign mdOvf     = reset && state_q == DONE && ovf_q;
  assign mdTimeout = reset && tmo_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: vector table, directed
// multdiv/reset sequences and randomized traffic vs a reference model.
module tb_pipeline_stall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inFD, inDX;
  logic        multdivRdy, multdivExc;
  logic        stallPC, stallFD, stallDX, bubbleDX, bubbleXM;
  logic        ctrlMULT, ctrlDIV, mdValid, mdOvf, mdTimeout;

  pipeline_stall_controller dut (
    .clock(clock), .reset(reset),
    .inFD(inFD), .inDX(inDX),
    .multdivRdy(multdivRdy), .multdivExc(multdivExc),
    .stallPC(stallPC), .stallFD(stallFD), .stallDX(stallDX),
    .bubbleDX(bubbleDX), .bubbleXM(bubbleXM),
    .ctrlMULT(ctrlMULT), .ctrlDIV(ctrlDIV),
    .mdValid(mdValid), .mdOvf(mdOvf), .mdTimeout(mdTimeout)
  );

  always #5 clock = ~clock;

  // [9]stallPC [8]stallFD [7]stallDX [6]bubbleDX [5]bubbleXM
  // [4]ctrlMULT [3]ctrlDIV [2]mdValid [1]mdOvf [0]mdTimeout
  logic [9:0] act;
  assign act = {stallPC, stallFD, stallDX, bubbleDX, bubbleXM,
                ctrlMULT, ctrlDIV, mdValid, mdOvf, mdTimeout};

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] last;

  // reference model: age counts cycles since a mul/div was seen in DX
  int m_age  = -1;
  bit m_done = 0;
  bit m_div  = 0;
  bit m_ovf  = 0;
  bit m_tmo  = 0;

  function automatic logic [31:0] rt(int rd, int rs, int rtr, int alu);
    rt = {5'd0, 5'(rd), 5'(rs), 5'(rtr), 5'd0, 5'(alu), 2'd0};
  endfunction

  function automatic logic [31:0] it(int op, int rd, int rs, int imm);
    it = {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic bit is_mul(logic [31:0] i);
    return i[31:27] == 0 && i[6:2] == 6;
  endfunction

  function automatic bit is_div(logic [31:0] i);
    return i[31:27] == 0 && i[6:2] == 7;
  endfunction

  function automatic bit load_use(logic [31:0] fd, logic [31:0] dx);
    int srcs[$];
    int op, rd;
    op = int'(fd[31:27]);
    rd = int'(dx[26:22]);
    if (dx[31:27] != 8 || rd == 0) return 0;
    srcs.push_back(int'(fd[21:17]));
    if (op == 0) srcs.push_back(int'(fd[16:12]));
    if (op == 2 || op == 4 || op == 6) srcs.push_back(int'(fd[26:22]));
    foreach (srcs[k]) if (srcs[k] == rd) return 1;
    return 0;
  endfunction

  function automatic logic [9:0] model_out(logic [31:0] fd,
      logic [31:0] dx, bit rst);
    logic [9:0] o;
    o = '0;
    if (!rst) return o;
    if (m_done) begin
      o[2] = 1'b1;
      o[1] = m_ovf;
    end else if ((m_age < 0 && (is_mul(dx) || is_div(dx))) || m_age >= 1) begin
      o[9:5] = 5'b11101;
      if (m_age == 1) begin
        o[4] = !m_div;
        o[3] = m_div;
      end
    end else if (load_use(fd, dx)) begin
      o[9:5] = 5'b11010;
    end
    o[0] = m_tmo;
    return o;
  endfunction

  task automatic model_step(logic [31:0] dx, bit rdy, bit exc, bit rst);
    if (!rst) begin
      m_age = -1; m_done = 0; m_div = 0; m_ovf = 0; m_tmo = 0;
    end else if (m_done) begin
      m_done = 0; m_age = -1;
    end else if (m_age < 0) begin
      if (is_mul(dx) || is_div(dx)) begin
        m_age = 1; m_div = is_div(dx);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rdy) begin
      m_done = 1; m_ovf = exc;
    end else if (m_age - 1 == 40) begin
      m_done = 1; m_ovf = 0; m_tmo = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // called at posedge+1; compares at negedge, returns at next posedge+1
  task automatic cyc(logic [31:0] fd, logic [31:0] dx,
      bit rdy, bit exc, bit rst, string tag);
    logic [9:0] exp;
    inFD = fd; inDX = dx;
    multdivRdy = rdy; multdivExc = exc; reset = rst;
    exp = model_out(fd, dx, rst);
    @(negedge clock);
    last = act;
    check(tag, 32'(act), 32'(exp));
    @(posedge clock);
    model_step(dx, rdy, exc, rst);
    #1;
  endtask

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic [4:0]  ex;
  } vec_t;

  vec_t tbl[11];
  logic [31:0] nop, add1, mul3, div4;
  int idx;
  bit seen;

  initial begin
    tbl[0]  = '{rt(6, 5, 7, 0),  it(8, 5, 1, 4), 5'b11010};
    tbl[1]  = '{rt(6, 7, 5, 0),  it(8, 5, 1, 4), 5'b11010};
    tbl[2]  = '{it(7, 5, 8, 0),  it(8, 5, 1, 4), 5'b00000};
    tbl[3]  = '{rt(1, 0, 0, 0),  it(8, 0, 1, 4), 5'b00000};
    tbl[4]  = '{it(2, 5, 9, 3),  it(8, 5, 1, 4), 5'b11010};
    tbl[5]  = '{it(5, 5, 9, 1),  it(8, 5, 1, 4), 5'b00000};
    tbl[6]  = '{it(7, 9, 5, 0),  it(8, 5, 1, 4), 5'b11010};
    tbl[7]  = '{rt(6, 5, 7, 0),  rt(5, 1, 2, 0), 5'b00000};
    tbl[8]  = '{it(5, 1, 2, 'h05000), it(8, 5, 1, 4), 5'b00000};
    tbl[9]  = '{it(6, 7, 1, 2),  it(8, 7, 2, 0), 5'b11010};
    tbl[10] = '{it(4, 7, 0, 0),  it(8, 7, 2, 0), 5'b11010};

    nop  = 32'd0;
    add1 = rt(1, 2, 3, 0);
    mul3 = rt(3, 1, 2, 6);
    div4 = rt(4, 1, 2, 7);
    inFD = '0; inDX = '0; multdivRdy = 0; multdivExc = 0;
    reset = 1'b0;
    @(posedge clock); #1;
    cyc(add1, mul3, 1, 1, 0, "reset_state");
    cyc(nop, nop, 0, 0, 1, "idle_nop");

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].fd, tbl[i].dx, 0, 0, 1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl", i), 32'(last[9:5]), 32'(tbl[i].ex));
    end

    // mul, ready on 5th busy cycle
    cyc(nop, mul3, 0, 0, 1, "mul_detect");
    check("mul_detect_hand", 32'(last), 32'b1110100000);
    cyc(nop, mul3, 0, 0, 1, "mul_start");
    check("mul_pulse", 32'(last[4:3]), 32'b10);
    for (int k = 1; k <= 5; k++)
      cyc(nop, mul3, k == 5, 0, 1, $sformatf("mul_busy%0d", k));
    check("mul_busy_stall", 32'(last[9:5]), 32'b11101);
    cyc(nop, mul3, 0, 0, 1, "mul_done");
    check("mul_done_hand", 32'(last), 32'b0000000100);
    cyc(nop, add1, 0, 0, 1, "mul_after");
    check("mul_after_hand", 32'(last), 32'd0);

    // div with exception
    cyc(nop, div4, 0, 0, 1, "div_detect");
    cyc(nop, div4, 0, 0, 1, "div_start");
    check("div_pulse", 32'(last[4:3]), 32'b01);
    cyc(nop, div4, 0, 0, 1, "div_busy1");
    cyc(nop, div4, 1, 1, 1, "div_busy2");
    cyc(nop, div4, 0, 0, 1, "div_done");
    check("div_done_hand", 32'(last[2:1]), 32'b11);
    cyc(nop, add1, 0, 0, 1, "div_after");

    // reset during busy
    cyc(nop, mul3, 0, 0, 1, "rb_detect");
    cyc(nop, mul3, 0, 0, 1, "rb_start");
    cyc(nop, mul3, 0, 0, 1, "rb_busy1");
    cyc(nop, mul3, 0, 0, 0, "rb_reset");
    check("rb_reset_hand", 32'(last), 32'd0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(nop, add1, 1, 0, 1, $sformatf("rb_after%0d", k));
      seen |= last[2];
    end
    check("rb_no_valid", 32'(seen), 32'd0);

    // timeout: done must land 42 cycles after detection
    idx = -1;
    for (int k = 0; k < 60 && idx < 0; k++) begin
      cyc(nop, mul3, 0, 0, 1, $sformatf("tmo%0d", k));
      if (last[2]) idx = k;
    end
    check("tmo_done_cycle", 32'(idx), 32'd42);
    check("tmo_flag", 32'(last[1:0]), 32'b01);
    cyc(nop, add1, 0, 0, 1, "tmo_after");
    cyc(nop, mul3, 0, 0, 1, "tmo_md2_det");
    cyc(nop, mul3, 0, 0, 1, "tmo_md2_st");
    cyc(nop, mul3, 1, 0, 1, "tmo_md2_busy");
    cyc(nop, add1, 0, 0, 1, "tmo_md2_done");
    check("tmo_sticky", 32'(last[0]), 32'd1);
    cyc(nop, add1, 0, 0, 0, "tmo_reset");
    cyc(nop, add1, 0, 0, 1, "tmo_cleared");
    check("tmo_cleared_hand", 32'(last[0]), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] fd, dx;
      int sel, fop;
      int ops[7] = '{0, 2, 4, 5, 6, 7, 8};
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: dx = rt($urandom_range(1, 3), 1, 2, 6);
        1: dx = rt($urandom_range(1, 3), 1, 2, 7);
        2, 3, 4: dx = it(8, $urandom_range(0, 3), 1, $urandom_range(0, 99));
        5: dx = rt($urandom_range(0, 3), 1, 2, $urandom_range(0, 5));
        default: dx = $urandom;
      endcase
      fop = ops[$urandom_range(0, 6)];
      fd = it(fop, $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom_range(0, 3), 12'(int'($urandom))});
      cyc(fd, dx, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) != 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
